// File: rtl/bcd_countdown_chain_pkg.sv
// Shared types and helpers for the BCD countdown chain: field widths, FSM state encoding
// and the Led7thanh seven-segment decoder.
package bcd_countdown_chain_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // Led7thanh: common-anode, active-low, bit order {g,f,e,d,c,b,a}; non-BCD codes blank
    function automatic logic [SEG_W-1:0] led7thanh(input logic [BCD_W-1:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_countdown_chain_digit.sv
// One BCD down-counting digit: wraps from 0 to its MAX and requests a borrow from the
// next digit up; also reports whether a preset fits within MAX.
module bcd_down_digit
    import bcd_countdown_chain_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = 4'd9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_en,
    input  logic             borrow_in,
    input  logic             load,
    input  logic [BCD_W-1:0] load_d,
    output logic [BCD_W-1:0] q,
    output logic             borrow_out,
    output logic             valid_in
);

    logic [BCD_W-1:0] r_q;
    logic             w_dec;

    assign w_dec      = dec_en & borrow_in;
    assign borrow_out = w_dec & (r_q == '0);
    assign valid_in   = (load_d <= MAX);
    assign q          = r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_d;
        end else if (w_dec) begin
            r_q <= (r_q == '0) ? MAX : r_q - BCD_W'(1);
        end
    end

endmodule

// File: rtl/bcd_countdown_chain.sv
// Multi-digit BCD countdown timer: preset load with per-digit range check, run/pause
// control, borrow-rippled decrement per tick, and a single-cycle expiry pulse.
module bcd_countdown_chain
    import bcd_countdown_chain_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter logic [31:0] DIGIT_MAX  = 32'h5959
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          load,
    input  logic [BCD_W*NUM_DIGITS-1:0]   load_value,
    input  logic                          start,
    input  logic                          pause,
    output logic [BCD_W*NUM_DIGITS-1:0]   count_bcd,
    output logic [SEG_W*NUM_DIGITS-1:0]   seg,
    output logic                          running,
    output logic                          zero,
    output logic                          done,
    output logic                          load_err
);

    localparam int unsigned CNT_W = BCD_W * NUM_DIGITS;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_running;
    logic                    r_done;
    logic                    r_load_err;
    logic                    w_done_nxt;
    logic                    w_load_err_nxt;
    logic                    w_load_en;
    logic                    w_dec_en;
    logic                    w_underflow;
    logic                    w_zero;
    logic                    w_is_one;
    logic [NUM_DIGITS-1:0]   w_valid;
    logic [CNT_W-1:0]        w_count;

    assign w_zero   = (w_count == '0);
    assign w_is_one = (w_count == CNT_W'(1));
    // Decrement is held off at zero so the count can never wrap below 0
    assign w_dec_en = (r_state == ST_RUN) & tick & ~pause & ~w_zero;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic w_bin;
        logic w_bout;

        if (g == 0) begin : g_lsb
            assign w_bin = 1'b1;
        end else begin : g_upper
            assign w_bin = g_digit[g-1].w_bout;
        end

        bcd_down_digit #(
            .MAX (DIGIT_MAX[BCD_W*g +: BCD_W])
        ) u_digit (
            .clk        (clk),
            .reset      (reset),
            .dec_en     (w_dec_en),
            .borrow_in  (w_bin),
            .load       (w_load_en),
            .load_d     (load_value[BCD_W*g +: BCD_W]),
            .q          (w_count[BCD_W*g +: BCD_W]),
            .borrow_out (w_bout),
            .valid_in   (w_valid[g])
        );

        assign seg[SEG_W*g +: SEG_W] = led7thanh(w_count[BCD_W*g +: BCD_W]);
    end

    assign w_underflow = g_digit[NUM_DIGITS-1].w_bout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_running  <= (w_state_nxt == ST_RUN);
            r_done     <= w_done_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    // Priorities: pause over start in RUN; load over start elsewhere
    always_comb begin
        w_state_nxt    = r_state;
        w_done_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;
        w_load_en      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (pause) begin
                    w_state_nxt = ST_PAUSED;
                end else if (w_zero || w_underflow) begin
                    w_state_nxt = ST_EXPIRED;
                end else if (tick && w_is_one) begin
                    w_state_nxt = ST_EXPIRED;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                if (load) begin
                    if (&w_valid) begin
                        w_load_en   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_load_err_nxt = 1'b1;
                    end
                end else if (start && !pause && !w_zero && (r_state != ST_EXPIRED)) begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    assign count_bcd = w_count;
    assign zero      = w_zero;
    assign running   = r_running;
    assign done      = r_done;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_bcd_countdown_chain.sv
// Scoreboard bench for bcd_countdown_chain: stimulus queues expected per-cycle outputs,
// an independent monitor pops and compares them on the falling edge.
module tb_bcd_countdown_chain;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick, load, start, pause;
    logic [15:0] load_value;
    logic [15:0] count_bcd;
    logic [27:0] seg;
    logic        running, zero, done, load_err;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
        logic        run;
        logic        dn;
        logic        le;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;

    bcd_countdown_chain #(
        .NUM_DIGITS (4),
        .DIGIT_MAX  (32'h5959)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .count_bcd  (count_bcd),
        .seg        (seg),
        .running    (running),
        .zero       (zero),
        .done       (done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [27:0] seg_exp(input logic [15:0] c);
        return {seg_of(c[15:12]), seg_of(c[11:8]), seg_of(c[7:4]), seg_of(c[3:0])};
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", nm, fld, act, exp, $time);
        end
    endtask

    // Monitor: compare every expectation due at this cycle
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.nm, e.cyc, cyc);
            end else begin
                chk(e.nm, "count",    32'(count_bcd), 32'(e.cnt));
                chk(e.nm, "seg",      32'(seg),       32'(seg_exp(e.cnt)));
                chk(e.nm, "running",  32'(running),   32'(e.run));
                chk(e.nm, "zero",     32'(zero),      32'(e.cnt == 16'h0000));
                chk(e.nm, "done",     32'(done),      32'(e.dn));
                chk(e.nm, "load_err", 32'(load_err),  32'(e.le));
            end
        end
    end

    task automatic step(input string nm, input logic t, input logic l, input logic [15:0] lv,
                        input logic s, input logic p,
                        input logic [15:0] ec, input logic er, input logic ed, input logic el);
        exp_t e;
        @(negedge clk);
        tick = t; load = l; load_value = lv; start = s; pause = p;
        e.cyc = cyc + 1; e.cnt = ec; e.run = er; e.dn = ed; e.le = el; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic pulse_reset(input string nm);
        exp_t e;
        @(negedge clk);
        reset = 1'b1; tick = 0; load = 0; start = 0; pause = 0; load_value = '0;
        e.cyc = cyc + 1; e.cnt = 16'h0000; e.run = 0; e.dn = 0; e.le = 0; e.nm = nm;
        sb.push_back(e);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; tick = 0; load = 0; start = 0; pause = 0; load_value = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        //      name          tick load value    start pause  count    run done lerr
        step("rst_state",     0, 0, 16'h0000, 0, 0,   16'h0000, 0, 0, 0);

        // Reset mid-RUN at 12:34
        step("ld_1234",       0, 1, 16'h1234, 0, 0,   16'h1234, 0, 0, 0);
        step("run_1234",      0, 0, 16'h0000, 1, 0,   16'h1234, 1, 0, 0);
        pulse_reset("rst_mid_run");
        step("after_rst",     0, 0, 16'h0000, 0, 0,   16'h0000, 0, 0, 0);

        // Borrow ripple 0102 -> 0101 -> 0100 -> 0059
        step("ld_0102",       0, 1, 16'h0102, 0, 0,   16'h0102, 0, 0, 0);
        step("run_0102",      0, 0, 16'h0000, 1, 0,   16'h0102, 1, 0, 0);
        step("tick_0101",     1, 0, 16'h0000, 0, 0,   16'h0101, 1, 0, 0);
        step("tick_0100",     1, 0, 16'h0000, 0, 0,   16'h0100, 1, 0, 0);
        step("tick_0059",     1, 0, 16'h0000, 0, 0,   16'h0059, 1, 0, 0);
        step("pause_0059",    0, 0, 16'h0000, 0, 1,   16'h0059, 0, 0, 0);

        // Expiry 0001 -> 0000 with one-cycle done
        step("ld_0001",       0, 1, 16'h0001, 0, 0,   16'h0001, 0, 0, 0);
        step("run_0001",      0, 0, 16'h0000, 1, 0,   16'h0001, 1, 0, 0);
        step("expire",        1, 0, 16'h0000, 0, 0,   16'h0000, 0, 1, 0);
        step("done_clear",    0, 0, 16'h0000, 0, 0,   16'h0000, 0, 0, 0);
        step("exp_tick",      1, 0, 16'h0000, 0, 0,   16'h0000, 0, 0, 0);
        step("exp_start",     0, 0, 16'h0000, 1, 0,   16'h0000, 0, 0, 0);

        // Load validation against per-digit max
        step("ld_0070_bad",   0, 1, 16'h0070, 0, 0,   16'h0000, 0, 0, 1);
        step("lerr_clear",    0, 0, 16'h0000, 0, 0,   16'h0000, 0, 0, 0);
        step("ld_0559",       0, 1, 16'h0559, 0, 0,   16'h0559, 0, 0, 0);
        step("ld_6000_bad",   0, 1, 16'h6000, 0, 0,   16'h0559, 0, 0, 1);
        step("ld_5959_max",   0, 1, 16'h5959, 0, 0,   16'h5959, 0, 0, 0);

        // Multi-digit borrow 1000 -> 0959
        step("ld_1000",       0, 1, 16'h1000, 0, 0,   16'h1000, 0, 0, 0);
        step("run_1000",      0, 0, 16'h0000, 1, 0,   16'h1000, 1, 0, 0);
        step("tick_0959",     1, 0, 16'h0000, 0, 0,   16'h0959, 1, 0, 0);

        // Pause wins over start; ticks ignored while paused
        step("pause_run",     0, 0, 16'h0000, 0, 1,   16'h0959, 0, 0, 0);
        step("ld_0030",       0, 1, 16'h0030, 0, 0,   16'h0030, 0, 0, 0);
        step("run_0030",      0, 0, 16'h0000, 1, 0,   16'h0030, 1, 0, 0);
        step("pause_start",   0, 0, 16'h0000, 1, 1,   16'h0030, 0, 0, 0);
        step("paused_tick1",  1, 0, 16'h0000, 0, 0,   16'h0030, 0, 0, 0);
        step("paused_tick2",  1, 0, 16'h0000, 0, 0,   16'h0030, 0, 0, 0);
        step("resume",        0, 0, 16'h0000, 1, 0,   16'h0030, 1, 0, 0);
        step("tick_0029",     1, 0, 16'h0000, 0, 0,   16'h0029, 1, 0, 0);

        // Load ignored in RUN; start at zero ignored; load beats start
        step("ld_in_run",     0, 1, 16'h0000, 0, 0,   16'h0029, 1, 0, 0);
        step("pause_0029",    0, 0, 16'h0000, 0, 1,   16'h0029, 0, 0, 0);
        step("ld_0000",       0, 1, 16'h0000, 0, 0,   16'h0000, 0, 0, 0);
        step("start_at_zero", 0, 0, 16'h0000, 1, 0,   16'h0000, 0, 0, 0);
        step("ld_and_start",  0, 1, 16'h0003, 1, 0,   16'h0003, 0, 0, 0);
        step("idle_hold",     0, 0, 16'h0000, 0, 0,   16'h0003, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
